// File: rtl/mux_pipe.sv
// mux_pipe: N_SRC-way operand selector feeding a STAGES-deep register chain with stall and flush.
// Define MUX_PIPE_ERR_EN to carry an out-of-range-select flag with each entry; otherwise sel_err is 0.
module mux_pipe #(
  parameter int WIDTH  = 32,
  parameter int N_SRC  = 3,
  parameter int SEL_W  = 2,
  parameter int STAGES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC*WIDTH-1:0] src,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   in_valid,
  input  logic                   stall,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rlt,
  output logic                   out_valid,
  output logic                   sel_err
);

  logic [WIDTH-1:0]  sel_data;
  logic [WIDTH-1:0]  data_q  [STAGES];
  logic [WIDTH-1:0]  data_d  [STAGES];
  logic [WIDTH-1:0]  up_data [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] up_vld;

  // Out-of-range selects fall back to the last source.
  always_comb begin
    sel_data = src[(N_SRC-1)*WIDTH +: WIDTH];
    for (int k = 0; k < N_SRC; k++) begin
      if (32'(sel) == 32'(k)) sel_data = src[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    up_vld[0]  = in_valid;
    up_data[0] = sel_data;
    for (int i = 1; i < STAGES; i++) begin
      up_vld[i]  = vld_q[i-1];
      up_data[i] = data_q[i-1];
    end
  end

  // Flush beats stall; data only reloads when the upstream entry is valid.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      data_d[i] = data_q[i];
      vld_d[i]  = vld_q[i];
      if (flush) begin
        vld_d[i] = 1'b0;
      end else if (!stall) begin
        vld_d[i] = up_vld[i];
        if (up_vld[i]) data_d[i] = up_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      vld_q <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign rlt       = data_q[STAGES-1];
  assign out_valid = vld_q[STAGES-1];

`ifdef MUX_PIPE_ERR_EN
  logic              sel_oor;
  logic [STAGES-1:0] err_q;
  logic [STAGES-1:0] err_d;
  logic [STAGES-1:0] up_err;

  assign sel_oor = (32'(sel) >= 32'(N_SRC));

  always_comb begin
    up_err[0] = in_valid & sel_oor;
    for (int i = 1; i < STAGES; i++) up_err[i] = err_q[i-1];
  end

  // The flag travels exactly like the data it describes, but is cleared by flush.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      err_d[i] = err_q[i];
      if (flush) begin
        err_d[i] = 1'b0;
      end else if (!stall && up_vld[i]) begin
        err_d[i] = up_err[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign sel_err = err_q[STAGES-1];
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_pipe.sv
// tb_mux_pipe: three mux_pipe configurations driven together and checked against a tick-indexed
// history model (entry accepted at advance t shows on the outputs at advance t+STAGES-1).
module tb_mux_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic [95:0] src_a = '0;
  logic [1:0]  sel_a = '0;
  logic [9:0]  src_b = '0;
  logic        sel_b = '0;
  logic [79:0] src_c = '0;
  logic [3:0]  sel_c = '0;

  logic [31:0] rlt_a;
  logic [4:0]  rlt_b, rlt_c;
  logic        ov_a, ov_b, ov_c;
  logic        se_a, se_b, se_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_pipe #(.WIDTH(32), .N_SRC(3), .SEL_W(2), .STAGES(2)) u_a (
    .clk(clk), .rst(rst), .src(src_a), .sel(sel_a), .in_valid(in_valid),
    .stall(stall), .flush(flush), .rlt(rlt_a), .out_valid(ov_a), .sel_err(se_a));

  mux_pipe #(.WIDTH(5), .N_SRC(2), .SEL_W(1), .STAGES(1)) u_b (
    .clk(clk), .rst(rst), .src(src_b), .sel(sel_b), .in_valid(in_valid),
    .stall(stall), .flush(flush), .rlt(rlt_b), .out_valid(ov_b), .sel_err(se_b));

  mux_pipe #(.WIDTH(5), .N_SRC(16), .SEL_W(4), .STAGES(4)) u_c (
    .clk(clk), .rst(rst), .src(src_c), .sel(sel_c), .in_valid(in_valid),
    .stall(stall), .flush(flush), .rlt(rlt_c), .out_valid(ov_c), .sel_err(se_c));

  // Reference history: every advancing edge gets a tick; flush/reset invalidate ticks <= ft.
  int          stg [3] = '{2, 1, 4};
  bit          h_vld  [0:4095];
  logic [31:0] h_data [3][0:4095];
  bit          h_err  [3][0:4095];
  logic [31:0] last_d [3];
  int          tick = 0;
  int          ft   = 0;

  function automatic logic [31:0] pick_a();
    int idx;
    idx = (int'(sel_a) < 3) ? int'(sel_a) : 2;
    return src_a[idx*32 +: 32];
  endfunction

  function automatic logic [31:0] pick_b();
    return {27'b0, src_b[int'(sel_b)*5 +: 5]};
  endfunction

  function automatic logic [31:0] pick_c();
    return {27'b0, src_c[int'(sel_c)*5 +: 5]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h (tick %0d)", tag, obs, exp, tick);
      end
  endtask

  task automatic cmp_inst(int i, logic ov, logic [31:0] r, logic se, bit was_rst);
    int k;
    bit ev;
    k  = tick - (stg[i] - 1);
    ev = 1'b0;
    if (k > ft) ev = h_vld[k];
    if (ev) last_d[i] = h_data[i][k];
    chk($sformatf("out_valid[%0d]", i), {31'b0, ov}, {31'b0, ev});
    chk($sformatf("rlt[%0d]", i), r, last_d[i]);
    if (ev) chk($sformatf("sel_err[%0d]", i), {31'b0, se}, {31'b0, h_err[i][k]});
    if (was_rst) chk($sformatf("sel_err_rst[%0d]", i), {31'b0, se}, 32'd0);
  endtask

  task automatic step(bit r, bit iv, bit st, bit fl);
    rst      = r;
    in_valid = iv;
    stall    = st;
    flush    = fl;
    @(posedge clk);
    if (r) begin
      ft = tick;
      for (int i = 0; i < 3; i++) last_d[i] = '0;
    end else if (fl) begin
      ft = tick;
    end else if (!st) begin
      tick++;
      h_vld[tick]     = iv;
      h_data[0][tick] = pick_a();
      h_data[1][tick] = pick_b();
      h_data[2][tick] = pick_c();
`ifdef MUX_PIPE_ERR_EN
      h_err[0][tick]  = iv && (int'(sel_a) >= 3);
`else
      h_err[0][tick]  = 1'b0;
`endif
      h_err[1][tick]  = 1'b0;
      h_err[2][tick]  = 1'b0;
    end
    #1;
    cmp_inst(0, ov_a, rlt_a, se_a, r);
    cmp_inst(1, ov_b, {27'b0, rlt_b}, se_b, r);
    cmp_inst(2, ov_c, {27'b0, rlt_c}, se_c, r);
  endtask

  task automatic rand_side();
    src_b = 10'($urandom);
    src_c = 80'({$urandom, $urandom, $urandom});
    sel_b = 1'($urandom);
    sel_c = 4'($urandom);
  endtask

  initial begin
    // Reset then stream 0x11, 0x22, 0x33.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_rlt_a", rlt_a, 32'd0);
    src_a = {32'h33, 32'h22, 32'h11};
    for (int s = 0; s < 3; s++) begin
      rand_side();
      sel_a = 2'(s);
      step(0, 1, 0, 0);
    end
    rand_side();
    step(0, 0, 0, 0);
    chk("stream_last", rlt_a, 32'h33);
    step(0, 0, 0, 0);

    // Out-of-range select falls back to source 2.
    sel_a = 2'd3;
    step(0, 1, 0, 0);
    sel_a = 2'd0;
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Stall mid-stream; the input offered during the stall is dropped.
    sel_a = 2'd0; step(0, 1, 0, 0);
    sel_a = 2'd1; step(0, 1, 0, 0);
    sel_a = 2'd2;
    for (int s = 0; s < 3; s++) begin
      rand_side();
      step(0, 1, 1, 0);
    end
    src_a = {32'h66, 32'h55, 32'h44};
    step(0, 1, 0, 0);
    for (int s = 0; s < 3; s++) step(0, 0, 0, 0);

    // Flush and stall together with two entries in flight.
    sel_a = 2'd0; step(0, 1, 0, 0);
    sel_a = 2'd1; step(0, 1, 0, 0);
    sel_a = 2'd2; step(0, 1, 1, 1);
    sel_a = 2'd0; step(0, 1, 0, 0);
    for (int s = 0; s < 4; s++) step(0, 0, 0, 0);

    // Valid gating with sources changing every cycle.
    for (int s = 0; s < 6; s++) begin
      src_a = {$urandom, $urandom, $urandom};
      sel_a = 2'($urandom);
      rand_side();
      step(0, 0, 0, 0);
    end

    // Every legal select in each configuration.
    for (int s = 0; s < 16; s++) begin
      src_a = {$urandom, $urandom, $urandom};
      rand_side();
      sel_a = 2'(s % 3);
      sel_b = 1'(s);
      sel_c = 4'(s);
      step(0, 1, 0, 0);
    end
    for (int s = 0; s < 4; s++) step(0, 0, 0, 0);

    // Random traffic including stalls, flushes and mid-stream resets.
    for (int s = 0; s < 300; s++) begin
      src_a = {$urandom, $urandom, $urandom};
      sel_a = 2'($urandom);
      rand_side();
      step(($urandom_range(0, 49) == 0), 1'($urandom), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0));
    end
    for (int s = 0; s < 5; s++) step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
